// File: rtl/compute_pkg.sv
// Shared definitions for compute_unit_pipe: opcodes, instruction field positions, FSM states.
package compute_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_LOAD = 4'h1,
        OP_ADD  = 4'h2,
        OP_SUB  = 4'h3,
        OP_AND  = 4'h4,
        OP_OR   = 4'h5,
        OP_NOT  = 4'h6,
        OP_XOR  = 4'h7,
        OP_SHL  = 4'h8,
        OP_SHR  = 4'h9,
        OP_MUL  = 4'hA,
        OP_CMP  = 4'hB
    } opcode_e;

    localparam int OPC_LSB  = 12;
    localparam int TGT_LSB  = 8;
    localparam int SRC0_LSB = 4;
    localparam int SRC1_LSB = 0;
    localparam int IMM_LSB  = 0;
    localparam int FIELD_W  = 4;
    localparam int IMM_W    = 8;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_MUL = 1'b1
    } state_e;

endpackage

// File: rtl/compute_mul_seq.sv
// Iterative shift-add multiplier: one partial product per cycle, DATA_W cycles per product.
module compute_mul_seq #(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic                  busy,
    output logic                  done,
    output logic [2*DATA_W-1:0]   product
);

    localparam int CW = $clog2(DATA_W);

    logic [2*DATA_W-1:0] mcand;
    logic [2*DATA_W-1:0] acc;
    logic [2*DATA_W-1:0] acc_nxt;
    logic [DATA_W-1:0]   mplier;
    logic [CW-1:0]       cnt;

    // product is the accumulator including the current iteration, so the
    // caller can commit it on the same edge as the final iteration
    assign acc_nxt = acc + (mplier[0] ? mcand : '0);
    assign done    = busy && (cnt == CW'(DATA_W - 1));
    assign product = acc_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            cnt    <= '0;
            mcand  <= {{DATA_W{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
        end else if (busy) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/compute_unit_pipe.sv
// Register-file ALU with one execute stage and a valid/ready instruction input.
// Optional iterative multiplier built when COMPUTE_UNIT_MUL_EN is defined.
module compute_unit_pipe
    import compute_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NREG   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       instruction,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [3:0]        out_reg_id,
    output logic              out_zero,
    output logic              out_carry,
    output logic              out_illegal
);

    localparam int IDW = $clog2(NREG);

    logic              ex_valid;
    logic [15:0]       ex_instr;
    logic [DATA_W-1:0] rf [NREG];

    opcode_e           ex_op;
    logic [3:0]        tgt, src0, src1;
    logic [7:0]        imm;
    logic [DATA_W-1:0] op_a, op_b, res_data;
    logic              res_carry;
    logic              legal, writes;

    assign ex_op = opcode_e'(ex_instr[OPC_LSB +: FIELD_W]);
    assign tgt   = ex_instr[TGT_LSB +: FIELD_W];
    assign src0  = ex_instr[SRC0_LSB +: FIELD_W];
    assign src1  = ex_instr[SRC1_LSB +: FIELD_W];
    assign imm   = ex_instr[IMM_LSB +: IMM_W];
    assign op_a  = rf[src0[IDW-1:0]];
    assign op_b  = rf[src1[IDW-1:0]];

    function automatic logic id_ok(input logic [3:0] id);
        return 32'(id) < NREG;
    endfunction

    function automatic logic shift_out(input logic [DATA_W-1:0] amt);
        return {1'b0, amt} >= (DATA_W + 1)'(DATA_W);
    endfunction

    // Returns {carry, data}; MUL is handled by the sequencer, not here
    function automatic logic [DATA_W:0] alu(input opcode_e op, input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b, input logic [7:0] imm8);
        logic [DATA_W:0] r;
        r = '0;
        case (op)
            OP_LOAD:        r = {1'b0, DATA_W'(imm8)};
            OP_ADD:         r = {1'b0, a} + {1'b0, b};
            OP_SUB, OP_CMP: r = {a < b, a - b};
            OP_AND:         r = {1'b0, a & b};
            OP_OR:          r = {1'b0, a | b};
            OP_NOT:         r = {1'b0, ~a};
            OP_XOR:         r = {1'b0, a ^ b};
            OP_SHL:         r = shift_out(b) ? '0 : {1'b0, a << b};
            OP_SHR:         r = shift_out(b) ? '0 : {1'b0, a >> b};
            default:        r = '0;
        endcase
        return r;
    endfunction

    assign {res_carry, res_data} = alu(ex_op, op_a, op_b, imm);

    always_comb begin
        legal  = 1'b0;
        writes = 1'b0;
        case (ex_op)
            OP_LOAD: begin
                legal  = id_ok(tgt);
                writes = 1'b1;
            end
            OP_NOT: begin
                legal  = id_ok(tgt) && id_ok(src0);
                writes = 1'b1;
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR: begin
                legal  = id_ok(tgt) && id_ok(src0) && id_ok(src1);
                writes = 1'b1;
            end
            OP_CMP: legal = id_ok(tgt) && id_ok(src0) && id_ok(src1);
`ifdef COMPUTE_UNIT_MUL_EN
            OP_MUL: legal = id_ok(tgt) && id_ok(src0) && id_ok(src1);
`endif
            default: legal = 1'b0;
        endcase
    end

`ifdef COMPUTE_UNIT_MUL_EN
    state_e                state;
    logic                  mul_start, mul_busy, mul_done;
    logic [2*DATA_W-1:0]   mul_prod;

    assign mul_start = (state == ST_RUN) && ex_valid && legal && (ex_op == OP_MUL);
    assign in_ready  = !rst && (state == ST_RUN) && !mul_busy && !(ex_valid && ex_op == OP_MUL);

    compute_mul_seq #(.DATA_W(DATA_W)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (op_a),
        .b       (op_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_prod)
    );
`else
    assign in_ready = !rst;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid    <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_reg_id  <= '0;
            out_zero    <= 1'b0;
            out_carry   <= 1'b0;
            out_illegal <= 1'b0;
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
`ifdef COMPUTE_UNIT_MUL_EN
            state       <= ST_RUN;
`endif
        end else begin
            out_valid   <= 1'b0;
            out_zero    <= 1'b0;
            out_carry   <= 1'b0;
            out_illegal <= 1'b0;
            ex_valid    <= in_valid && in_ready;
            if (in_valid && in_ready) ex_instr <= instruction;

            // execute stage: ex register -> result pulse and register write
            if (ex_valid && ex_op != OP_NOP) begin
                out_reg_id <= tgt;
                if (!legal) begin
                    out_valid   <= 1'b1;
                    out_illegal <= 1'b1;
                    out_data    <= '0;
                end
`ifdef COMPUTE_UNIT_MUL_EN
                else if (ex_op == OP_MUL) begin
                    state <= ST_MUL;
                end
`endif
                else begin
                    out_valid <= 1'b1;
                    out_data  <= res_data;
                    out_zero  <= (res_data == '0);
                    out_carry <= res_carry;
                    if (writes) rf[tgt[IDW-1:0]] <= res_data;
                end
            end

`ifdef COMPUTE_UNIT_MUL_EN
            // ex_instr is frozen while multiplying, so tgt still names the target
            if (state == ST_MUL && mul_done) begin
                state                <= ST_RUN;
                rf[tgt[IDW-1:0]]     <= mul_prod[DATA_W-1:0];
                out_valid            <= 1'b1;
                out_reg_id           <= tgt;
                out_data             <= mul_prod[DATA_W-1:0];
                out_zero             <= (mul_prod[DATA_W-1:0] == '0);
                out_carry            <= |mul_prod[2*DATA_W-1:DATA_W];
            end
`endif
        end
    end

endmodule

// File: tb/tb_compute_unit_pipe.sv
// Randomized, self-checking bench for compute_unit_pipe (DATA_W=8, NREG=8).
module tb_compute_unit_pipe;

    localparam int DW = 8;
    localparam int NR = 8;
`ifdef COMPUTE_UNIT_MUL_EN
    localparam bit MUL_ON = 1'b1;
`else
    localparam bit MUL_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [15:0]   instruction = '0;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [3:0]    out_reg_id;
    logic          out_zero, out_carry, out_illegal;

    compute_unit_pipe #(.DATA_W(DW), .NREG(NR)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instruction (instruction),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_reg_id  (out_reg_id),
        .out_zero    (out_zero),
        .out_carry   (out_carry),
        .out_illegal (out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       ill;
        logic [7:0] data;
        logic [3:0] id;
        logic       z;
        logic       c;
        int         cyc;
    } pulse_t;

    pulse_t obs_q[$];
    pulse_t exp_q[$];
    int     cyc = 0;
    int     idle_bad = 0;
    int     errors = 0;
    int     checks = 0;
    int     acc_cyc = 0;
    int     mrf[NR];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid === 1'b1)
            obs_q.push_back('{out_illegal, out_data, out_reg_id, out_zero, out_carry, cyc});
        else if (out_zero !== 1'b0 || out_carry !== 1'b0 || out_illegal !== 1'b0 || out_valid !== 1'b0)
            idle_bad++;
    end

    function automatic logic [15:0] rr(input int op, input int t, input int s0, input int s1);
        rr = {op[3:0], t[3:0], s0[3:0], s1[3:0]};
    endfunction

    function automatic logic [15:0] ld(input int t, input int imm);
        ld = {4'h1, t[3:0], imm[7:0]};
    endfunction

    // Behavioural model: returns 1 when the instruction should produce a pulse
    function automatic bit model(input logic [15:0] ins, output pulse_t p, output int lat);
        int op = ins[15:12];
        int t  = ins[11:8];
        int s0 = ins[7:4];
        int s1 = ins[3:0];
        int imm = ins[7:0];
        int a, b, r;
        bit ok, wr, c;
        p.ill = 0; p.data = 0; p.id = ins[11:8]; p.z = 0; p.c = 0; p.cyc = 0;
        lat = 1;
        if (op == 0) return 0;
        a = (s0 < NR) ? mrf[s0] : 0;
        b = (s1 < NR) ? mrf[s1] : 0;
        ok = (t < NR); wr = 1; c = 0; r = 0;
        case (op)
            1:  r = imm;
            2:  begin r = a + b; c = (r > 255); end
            3:  begin c = (a < b); r = a - b; end
            11: begin c = (a < b); r = a - b; wr = 0; end
            4:  r = a & b;
            5:  r = a | b;
            6:  r = ~a;
            7:  r = a ^ b;
            8:  r = (b >= DW) ? 0 : (a << b);
            9:  r = (b >= DW) ? 0 : (a >> b);
            10: begin r = a * b; c = (r > 255); ok = ok && MUL_ON; end
            default: ok = 0;
        endcase
        if (op == 6) ok = ok && (s0 < NR);
        else if (op >= 2 && op <= 11) ok = ok && (s0 < NR) && (s1 < NR);
        r = r & 255;
        if (!ok) begin
            p.ill = 1;
            return 1;
        end
        if (op == 10) lat = 1 + DW;
        p.data = r[7:0];
        p.z = (r == 0);
        p.c = c;
        if (wr) mrf[t] = r;
        return 1;
    endfunction

    task automatic send(input logic [15:0] ins);
        pulse_t p;
        int n = 0;
        int lat;
        in_valid = 1'b1;
        instruction = ins;
        while (!in_ready && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, n);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        acc_cyc = cyc;
        in_valid = 1'b0;
        if (model(ins, p, lat)) begin
            p.cyc = acc_cyc + lat;
            exp_q.push_back(p);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; instruction = '0;
        idle(3);
        for (int i = 0; i < NR; i++) mrf[i] = 0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %0b want 0", in_ready); end
        checks++; if (out_valid !== 1'b0 || out_illegal !== 1'b0) begin errors++; $display("FAIL reset_valid: got v=%0b ill=%0b want 0 0", out_valid, out_illegal); end
        checks++; if (out_data !== '0 || out_reg_id !== '0) begin errors++; $display("FAIL reset_data: got data=%02h id=%0d want 00 0", out_data, out_reg_id); end
        checks++; if (out_zero !== 1'b0 || out_carry !== 1'b0) begin errors++; $display("FAIL reset_flags: got z=%0b c=%0b want 0 0", out_zero, out_carry); end
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %0b want 1", in_ready); end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_basic();
        pulse_t e, o;
        send(ld(1, 8'h05));
        send(ld(2, 8'h03));
        send(rr(2, 3, 1, 2));
        idle(4);
        checks++;
        if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL basic_count: got %0d pulses want %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (o.ill !== e.ill || o.data !== e.data || o.id !== e.id || o.z !== e.z || o.c !== e.c || o.cyc !== e.cyc) begin
                errors++;
                $display("FAIL basic: got ill=%0b d=%02h id=%0d z=%0b c=%0b cyc=%0d want ill=%0b d=%02h id=%0d z=%0b c=%0b cyc=%0d",
                         o.ill, o.data, o.id, o.z, o.c, o.cyc, e.ill, e.data, e.id, e.z, e.c, e.cyc);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_flags();
        pulse_t e, o;
        send(ld(1, 8'hFF));
        send(ld(2, 8'h01));
        send(rr(2, 3, 1, 2));
        send(rr(3, 4, 2, 1));
        send(ld(0, 8'h33));
        send(rr(11, 0, 1, 1));
        send(rr(5, 7, 0, 0));
        idle(4);
        checks++;
        if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL flags_count: got %0d pulses want %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (o.ill !== e.ill || o.data !== e.data || o.id !== e.id || o.z !== e.z || o.c !== e.c || o.cyc !== e.cyc) begin
                errors++;
                $display("FAIL flags: got ill=%0b d=%02h id=%0d z=%0b c=%0b cyc=%0d want ill=%0b d=%02h id=%0d z=%0b c=%0b cyc=%0d",
                         o.ill, o.data, o.id, o.z, o.c, o.cyc, e.ill, e.data, e.id, e.z, e.c, e.cyc);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_logic_shift();
        pulse_t e, o;
        send(ld(6, 8'h0F));
        send(rr(6, 5, 6, 0));
        send(ld(1, 8'h81));
        send(ld(2, 8'h01));
        send(rr(8, 3, 1, 2));
        send(ld(2, 8'h08));
        send(rr(9, 3, 1, 2));
        send(rr(8, 4, 1, 2));
        send(rr(4, 4, 1, 6));
        send(rr(7, 4, 1, 5));
        idle(4);
        checks++;
        if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL logic_count: got %0d pulses want %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (o.ill !== e.ill || o.data !== e.data || o.id !== e.id || o.z !== e.z || o.c !== e.c || o.cyc !== e.cyc) begin
                errors++;
                $display("FAIL logic_shift: got ill=%0b d=%02h id=%0d z=%0b c=%0b cyc=%0d want ill=%0b d=%02h id=%0d z=%0b c=%0b cyc=%0d",
                         o.ill, o.data, o.id, o.z, o.c, o.cyc, e.ill, e.data, e.id, e.z, e.c, e.cyc);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_illegal();
        pulse_t e, o;
        send(ld(1, 8'h5A));
        send(ld(9, 8'hC3));
        send(rr(5, 7, 1, 1));
        send(rr(13, 1, 1, 1));
        send(rr(0, 1, 2, 3));
        send(rr(2, 4, 1, 12));
        send(rr(2, 1, 1, 1));
        idle(4);
        checks++;
        if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL illegal_count: got %0d pulses want %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (o.ill !== e.ill || o.data !== e.data || o.id !== e.id || o.z !== e.z || o.c !== e.c || o.cyc !== e.cyc) begin
                errors++;
                $display("FAIL illegal: got ill=%0b d=%02h id=%0d z=%0b c=%0b cyc=%0d want ill=%0b d=%02h id=%0d z=%0b c=%0b cyc=%0d",
                         o.ill, o.data, o.id, o.z, o.c, o.cyc, e.ill, e.data, e.id, e.z, e.c, e.cyc);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_mul();
        pulse_t e, o;
        int n = 0;
        int mul_acc;
        send(ld(1, 8'h10));
        send(ld(2, 8'h11));
        send(rr(10, 3, 1, 2));
        mul_acc = acc_cyc;
        while (!in_ready && n < 40) begin
            n++;
            @(posedge clk); #1;
        end
        checks++;
        if (n != (MUL_ON ? DW + 1 : 0)) begin errors++; $display("FAIL mul_stall: got %0d busy cycles want %0d", n, MUL_ON ? DW + 1 : 0); end
        send(rr(2, 4, 3, 1));
        checks++;
        if (acc_cyc - mul_acc != (MUL_ON ? DW + 2 : 1)) begin errors++; $display("FAIL mul_next_accept: got %0d cycles after MUL want %0d", acc_cyc - mul_acc, MUL_ON ? DW + 2 : 1); end
        idle(DW + 4);
        checks++;
        if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL mul_count: got %0d pulses want %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (o.ill !== e.ill || o.data !== e.data || o.id !== e.id || o.z !== e.z || o.c !== e.c || o.cyc !== e.cyc) begin
                errors++;
                $display("FAIL mul: got ill=%0b d=%02h id=%0d z=%0b c=%0b cyc=%0d want ill=%0b d=%02h id=%0d z=%0b c=%0b cyc=%0d",
                         o.ill, o.data, o.id, o.z, o.c, o.cyc, e.ill, e.data, e.id, e.z, e.c, e.cyc);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_mid_reset();
        pulse_t e, o;
        send(ld(3, 8'h77));
        send(ld(1, 8'h10));
        send(ld(2, 8'h11));
        idle(3);
        obs_q.delete(); exp_q.delete();
        if (MUL_ON) begin
            in_valid = 1'b1;
            instruction = rr(10, 3, 1, 2);
            @(posedge clk); #1;
            in_valid = 1'b0;
            idle(4);
        end
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        for (int i = 0; i < NR; i++) mrf[i] = 0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_ready: got %0b want 1", in_ready); end
        idle(DW + 4);
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL mid_reset_pulse: got %0d pulses want 0", obs_q.size()); end
        obs_q.delete();
        for (int i = 0; i < NR; i++) send(rr(5, i, i, i));
        idle(4);
        checks++;
        if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL mid_reset_count: got %0d pulses want %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (o.ill !== e.ill || o.data !== e.data || o.id !== e.id || o.z !== e.z || o.c !== e.c || o.cyc !== e.cyc) begin
                errors++;
                $display("FAIL mid_reset_regs: got ill=%0b d=%02h id=%0d z=%0b c=%0b cyc=%0d want ill=%0b d=%02h id=%0d z=%0b c=%0b cyc=%0d",
                         o.ill, o.data, o.id, o.z, o.c, o.cyc, e.ill, e.data, e.id, e.z, e.c, e.cyc);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_random();
        pulse_t e, o;
        int op;
        for (int i = 0; i < 300; i++) begin
            op = ($urandom_range(0, 3) == 0) ? 1 : $urandom_range(0, 15);
            if (op == 1) send(ld($urandom_range(0, 9), $urandom_range(0, 255)));
            else         send(rr(op, $urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9)));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        idle(DW + 4);
        checks++;
        if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL random_count: got %0d pulses want %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (o.ill !== e.ill || o.data !== e.data || o.id !== e.id || o.z !== e.z || o.c !== e.c || o.cyc !== e.cyc) begin
                errors++;
                $display("FAIL random: got ill=%0b d=%02h id=%0d z=%0b c=%0b cyc=%0d want ill=%0b d=%02h id=%0d z=%0b c=%0b cyc=%0d",
                         o.ill, o.data, o.id, o.z, o.c, o.cyc, e.ill, e.data, e.id, e.z, e.c, e.cyc);
            end
        end
        obs_q.delete(); exp_q.delete();
        checks++;
        if (idle_bad != 0) begin errors++; $display("FAIL idle_flags: got %0d cycles with flags set outside a pulse, want 0", idle_bad); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_flags();
        test_logic_shift();
        test_illegal();
        test_mul();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule

// File: doc/compute_unit_pipe.md
# compute_unit_pipe

Parametrised successor to the 8-bit compute unit: a register-file ALU with configurable data width and register count. It accepts 16-bit instructions over a valid/ready handshake and executes them in a single execute stage. Each result is reported as a one-cycle output pulse carrying flags. An optional iterative multiplier stalls the input while it runs. The block sits between the instruction source (the TT I/O front end) and the result/readback logic.

## Interface
- DATA_W, default 8: register and ALU width; legal range 4..32
- NREG, default 16: number of registers; legal range 2..16
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  instruction present
- in_ready  out  1  block can accept; forced 0 while rst is high
- instruction  in  16  [15:12] opcode, [11:8] tgt, [7:4] src0, [3:0] src1, [7:0] imm
- out_valid  out  1  one-cycle result pulse
- out_data  out  DATA_W  result value
- out_reg_id  out  4  target id of the reported instruction
- out_zero  out  1  result == 0
- out_carry  out  1  carry/borrow/overflow flag (see Operation)
- out_illegal  out  1  instruction was rejected

## Operation
- Accept when in_valid && in_ready. The instruction is captured into the execute register (ex_valid, ex_instr).
- Opcodes:
  - 0 NOP: no write, no pulse.
  - 1 LOAD: R[tgt] = imm, zero-extended to DATA_W or truncated if DATA_W < 8.
  - 2 ADD: carry = carry out.
  - 3 SUB: carry = borrow, i.e. R[src0] < R[src1].
  - 4 AND.
  - 5 OR.
  - 6 NOT: bitwise ~R[src0].
  - 7 XOR.
  - 8 SHL / 9 SHR: logical shift of R[src0] by R[src1]; an amount ≥ DATA_W gives 0.
  - A MUL: low DATA_W bits of the product; carry = high half nonzero.
  - B CMP: computes SUB and reports data and flags, with no write.
  - C–F: illegal.
- out_carry is 0 for every other opcode.
- Illegal cases are opcodes C–F, any tgt/src id ≥ NREG, and MUL when compiled out.
  - Response: out_valid=1, out_illegal=1, out_data=0, out_zero=0, out_carry=0, and no register write.
- Every non-NOP instruction produces exactly one out_valid pulse, in acceptance order.
- FSM states:
  - RUN: default.
  - MUL: entered from RUN when ex holds a legal MUL. It runs DATA_W shift-add iterations, writes R[tgt], pulses the output, then returns to RUN.
- in_ready = !rst && state==RUN && !(ex_valid && ex_op==MUL).
- The register file resets to all zeros.

## Timing
- Instruction accepted at edge k.
  - Single-cycle op: register write and output registers update at edge k+1. The result is visible in the cycle after k+1.
  - MUL: operands latch at edge k+1. Iterations run at edges k+2..k+1+DATA_W. Write and out_valid occur at edge k+1+DATA_W. in_ready returns high in the cycle after that edge.
- Throughput is one instruction per cycle for non-MUL ops.
- Back-to-back dependency: the instruction accepted at k+1 reads at k+2 and sees the value written at k+1. No forwarding path is needed.
- Writes to the same tgt from consecutive instructions: the later one wins.
- out_valid, out_illegal, out_zero and out_carry are all 0 in any cycle without a pulse. out_data and out_reg_id hold their last values.
- Reset values: out_valid 0, out_data 0, out_reg_id 0, out_zero 0, out_carry 0, out_illegal 0, FSM RUN, ex_valid 0, all R 0.
- Reset during MUL aborts it: no write, no pulse.

## Configuration
- COMPUTE_UNIT_MUL_EN defined: the MUL opcode, the MUL FSM state and the multiplier are built.
- COMPUTE_UNIT_MUL_EN undefined:
  - Opcode A is illegal and produces an illegal pulse at single-cycle latency.
  - The FSM is permanently RUN.
  - in_ready depends only on rst.

## Structure
- Shared package compute_pkg holds:
  - the opcode enum (OP_NOP..OP_CMP)
  - instruction field position constants
  - the FSM state enum
- Sub-module compute_mul_seq holds the iterative shift-add multiplier: start, operands, busy, done, product[2*DATA_W-1:0]. It is instantiated only under COMPUTE_UNIT_MUL_EN.

## Test plan
- Reset, then LOAD R1=0x05, LOAD R2=0x03, ADD R3=R1+R2 → pulses 05, 03, then 08 with carry 0. All three are issued back-to-back and produce one pulse per cycle.
- LOAD R1=0xFF, LOAD R2=0x01 → ADD R3 gives 00 with zero=1, carry=1. SUB R4=R2-R1 gives 02 with carry=1. CMP R1,R1 gives 00 with zero=1, and R0 is unchanged.
- NOT R5=~0x0F gives F0. SHL of 0x81 by 1 gives 02. SHR by 8 gives 00.
- Illegal cases, with NREG=8:
  - tgt=9 → out_illegal=1 and no write.
  - opcode 0xD → out_illegal=1.
  - NOP → no pulse.
- MUL 0x10*0x11 (DATA_W=8) → in_ready low for 9 cycles after acceptance; the result pulse gives 0x10 with carry=1. A following ADD is accepted only afterwards. Without the macro, the same opcode gives an illegal pulse at 1-cycle latency.
- Assert rst mid-MUL → no pulse, R[tgt] and all registers 0, and in_ready=1 in the cycle after rst drops.
